cla_4bit: RTL and testbench

//   Registered 4-bit carry-look-ahead adder slice: S = A + B + Cin, plus group generate/propagate.

---
 rtl/cla_4bit.sv | 158 +++++++++++++++
 tb/tb_cla_4bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cla_4bit.sv
// -----------------------------------------------------------------------------
// cla_4bit
//   Registered 4-bit carry-look-ahead adder slice: {Cout, S} = A + B + Cin.
//   Also produces the group generate/propagate pair (Gout, Pout), so several
//   slices can feed a second-level look-ahead unit for wider adders.
//
//   Carries are flattened sum-of-products terms built from the bit
//   generate/propagate signals. No carry ripples from one bit to the next.
//
//   Optional build macro: CLA_INPUT_REG_EN
//     defined   : A, B and Cin are captured in input flops first. Latency is
//                 2 clocks.
//     undefined : A, B and Cin drive the look-ahead logic directly. Latency is
//                 1 clock.
//   The port list, reset values and arithmetic are the same in both builds.
// -----------------------------------------------------------------------------
module cla_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       Gout,
    output logic       Pout
);

    // Operands as seen by the look-ahead logic.
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_cin;

`ifdef CLA_INPUT_REG_EN
    // Input stage: retime the operands to ease timing into the adder.
    logic [3:0] a_d;
    logic [3:0] a_q;
    logic [3:0] b_d;
    logic [3:0] b_q;
    logic       cin_d;
    logic       cin_q;

    // Next-state of the input flops: a plain capture on every edge.
    always_comb begin
        a_d   = A;
        b_d   = B;
        cin_d = Cin;
    end

    // Input flops. They clear with reset so that no X enters the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= 4'b0000;
            b_q   <= 4'b0000;
            cin_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
        end
    end

    assign op_a   = a_q;
    assign op_b   = b_q;
    assign op_cin = cin_q;
`else
    assign op_a   = A;
    assign op_b   = B;
    assign op_cin = Cin;
`endif

    // Bit-level generate and propagate. Propagate is XOR, so it can be
    // reused directly to form the sum bits.
    logic [3:0] g;
    logic [3:0] p;

    // Per-bit generate/propagate.
    always_comb begin
        g = 4'b0000;
        p = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            g[i] = op_a[i] & op_b[i];
            p[i] = op_a[i] ^ op_b[i];
        end
    end

    // Internal carries. c[0] is the carry in and c[4] is the carry out.
    logic [4:0] c;
    logic       grp_g;
    logic       grp_p;

    // Group terms. Gout does not depend on Cin, so a second-level unit
    // can combine slices without waiting on carries.
    always_comb begin
        grp_g = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        grp_p = p[3] & p[2] & p[1] & p[0];
    end

    // Two-level look-ahead carries. Each carry is one flat OR of AND terms.
    always_comb begin
        c    = 5'b00000;
        c[0] = op_cin;
        c[1] = g[0]
             | (p[0] & op_cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & op_cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & op_cin);
        c[4] = grp_g
             | (grp_p & op_cin);
    end

    // Output register next-state: sum bits, carry out and group pair.
    logic [3:0] s_d;
    logic [3:0] s_q;
    logic       cout_d;
    logic       cout_q;
    logic       gout_d;
    logic       gout_q;
    logic       pout_d;
    logic       pout_q;

    // Sum and flag next-state from the look-ahead network.
    always_comb begin
        s_d    = p ^ c[3:0];
        cout_d = c[4];
        gout_d = grp_g;
        pout_d = grp_p;
    end

    // Output register. It loads every edge. Reset clears it at once and
    // takes priority over the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= 4'b0000;
            cout_q <= 1'b0;
            gout_q <= 1'b0;
            pout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            gout_q <= gout_d;
            pout_q <= pout_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign Gout = gout_q;
    assign Pout = pout_q;

endmodule

// File: tb/tb_cla_4bit.sv
// -----------------------------------------------------------------------------
// tb_cla_4bit
//   Drives cla_4bit with directed, exhaustive and random operands.
//   A reference model based on integer addition pushes the expected
//   {Pout, Gout, Cout, S} into exp_q. The monitor pops exp_q once the result
//   for each issued operand set appears. Reset behaviour is checked directly.
//   Set CLA_INPUT_REG_EN to match the RTL build.
// -----------------------------------------------------------------------------
module tb_cla_4bit;

`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout;
    logic       Gout;
    logic       Pout;

    logic [6:0] exp_q[$];
    logic       issue;
    logic [1:0] vld_sr;
    int         checks;
    int         failures;

    cla_4bit dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout),
        .Gout (Gout),
        .Pout (Pout)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // The model uses whole-number addition only. Group generate means that
    // A+B already overflows 4 bits. Group propagate means that A+B is exactly
    // 15, so an incoming carry would pass through all four bits.
    function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic c);
        int ab;
        int total;
        logic [4:0] sum5;
        ab    = int'(a) + int'(b);
        total = ab + int'(c);
        sum5  = total[4:0];
        return {(ab == 15), (ab > 15), sum5};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(negedge clk);
        A     = a;
        B     = b;
        Cin   = c;
        issue = 1'b1;
        exp_q.push_back(model(a, b, c));
    endtask

    task automatic idle_and_drain;
        @(negedge clk);
        issue = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results never appeared, required 0 pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({Pout, Gout, Cout, S} !== 7'b0) begin
            failures++;
            $display("FAIL %s: got P=%b G=%b C=%b S=%b, required all 0", name, Pout, Gout, Cout, S);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic       cur;
        logic [6:0] exp_v;
        cur = issue;
        #1;
        if (rst) begin
            vld_sr = 2'b00;
        end else begin
            vld_sr = {vld_sr[0], cur};
            if (vld_sr[LAT-1]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow: output present with empty expected queue");
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({Pout, Gout, Cout, S} !== exp_v) begin
                        failures++;
                        $display("FAIL sb_result: got P=%b G=%b C=%b S=%b, required P=%b G=%b C=%b S=%b",
                                 Pout, Gout, Cout, S, exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;
        issue    = 1'b0;
        vld_sr   = 2'b00;
        A        = 4'h0;
        B        = 4'h0;
        Cin      = 1'b0;
        rst      = 1'b0;

        // Asynchronous reset before any clock edge, then reset held across an edge.
        #2 rst = 1'b1;
        #1 check_zero("reset_async_t0");
        @(posedge clk);
        #1 check_zero("reset_held_edge");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        drive(4'b0011, 4'b0101, 1'b0);
        drive(4'b1111, 4'b0001, 1'b0);
        drive(4'b1010, 4'b0101, 1'b1);
        drive(4'b1010, 4'b0101, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b1000, 4'b1000, 1'b0);
        idle_and_drain();

        // Load the all-ones case, then pulse reset in the middle of a cycle.
        drive(4'b1111, 4'b1111, 1'b1);
        idle_and_drain();
        #2 rst = 1'b1;
        #1 check_zero("reset_mid_cycle");
        @(posedge clk);
        #1 check_zero("reset_through_edge");
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive sweep, back to back.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            drive(v[8:5], v[4:1], v[0]);
        end

        // Random operands.
        for (int i = 0; i < 200; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        idle_and_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so that the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
